// File: rtl/kp_collector_pkg.sv
// Shared types and record layout for the keypoint collector: FSM states, record widths,
// field offsets of the keypoint and terminator records, and the record packing helpers.
package kp_collector_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_TERM    = 2'd2
    } state_t;

    localparam int KP_W  = 52;
    localparam int REC_W = KP_W + 1;  // eof flag sits above the data word

    localparam int X_LSB     = 42;
    localparam int Y_LSB     = 32;
    localparam int SCORE_LSB = 24;
    localparam int COS_LSB   = 12;
    localparam int SIN_LSB   = 0;

    localparam int TERM_DROP_LSB = 16;
    localparam int TERM_KP_LSB   = 0;

    function automatic logic [KP_W-1:0] pack_kp(input logic [9:0]  x,
                                                input logic [9:0]  y,
                                                input logic [7:0]  score,
                                                input logic [11:0] cos_v,
                                                input logic [11:0] sin_v);
        logic [KP_W-1:0] r;
        r = '0;
        r[X_LSB     +: 10] = x;
        r[Y_LSB     +: 10] = y;
        r[SCORE_LSB +: 8]  = score;
        r[COS_LSB   +: 12] = cos_v;
        r[SIN_LSB   +: 12] = sin_v;
        return r;
    endfunction

    function automatic logic [KP_W-1:0] pack_term(input logic [15:0] drop_cnt,
                                                  input logic [15:0] kp_cnt);
        logic [KP_W-1:0] r;
        r = '0;
        r[TERM_DROP_LSB +: 16] = drop_cnt;
        r[TERM_KP_LSB   +: 16] = kp_cnt;
        return r;
    endfunction

endpackage

// File: rtl/kp_collector_if.sv
// Keypoint record stream (valid/ready) from the collector to the descriptor/matching stage.
interface kp_collector_if;
    import kp_collector_pkg::*;

    logic            kp_valid;
    logic            kp_ready;
    logic [KP_W-1:0] kp_data;
    logic            kp_eof;

    modport master (output kp_valid, output kp_data, output kp_eof, input  kp_ready);
    modport slave  (input  kp_valid, input  kp_data, input  kp_eof, output kp_ready);

endinterface

// File: rtl/kp_collector_fifo.sv
// First-word fall-through FIFO holding keypoint and terminator records.
// Pointers carry one extra wrap bit so full and empty are told apart by the difference.
module kp_collector_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head is forced to zero while empty so stale storage never reaches the outputs.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/kp_collector.sv
// Collects flagged keypoints from the FAST detector into a FIFO and closes each frame with a
// terminator record. Optional score filter: define KP_SCORE_FILTER_EN.
module kp_collector
    import kp_collector_pkg::*;
#(
    parameter int         DEPTH     = 64,
    parameter logic [7:0] MIN_SCORE = 8'd30
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_end,
    input  logic             i_flag,
    input  logic [7:0]       i_score,
    input  logic [9:0]       i_coordinate_X,
    input  logic [9:0]       i_coordinate_Y,
    input  logic [11:0]      i_cos,
    input  logic [11:0]      i_sin,
    kp_collector_if.master   kp,
    output logic             o_frame_done,
    output logic             o_overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state, state_nx;
    logic [15:0]      kp_cnt;
    logic [15:0]      drop_cnt;
    logic             start_pend;
    logic             score_ok;
    logic             keypoint;
    logic             push, pop, accept, drop, clr;
    logic [REC_W-1:0] wdata, rdata;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef KP_SCORE_FILTER_EN
    assign score_ok = (i_score >= MIN_SCORE);
`else
    logic unused_min_score;
    assign unused_min_score = ^MIN_SCORE;
    assign score_ok = 1'b1;
`endif

    assign keypoint = i_flag & score_ok;

    always_comb begin
        state_nx     = state;
        push         = 1'b0;
        wdata        = '0;
        accept       = 1'b0;
        drop         = 1'b0;
        clr          = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nx = S_COLLECT;
                    clr      = 1'b1;
                end
            end
            S_COLLECT: begin
                // One slot is always held back so the terminator can be written.
                if (keypoint) begin
                    if (fifo_count < CW'(DEPTH - 1)) begin
                        push   = 1'b1;
                        accept = 1'b1;
                        wdata  = {1'b0, pack_kp(i_coordinate_X, i_coordinate_Y, i_score, i_cos, i_sin)};
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (i_end) state_nx = S_TERM;
            end
            S_TERM: begin
                drop = keypoint;
                if (!fifo_full) begin
                    push         = 1'b1;
                    wdata        = {1'b1, pack_term(drop_cnt, kp_cnt)};
                    o_frame_done = 1'b1;
                    if (start_pend || i_start) begin
                        state_nx = S_COLLECT;
                        clr      = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            kp_cnt     <= '0;
            drop_cnt   <= '0;
            o_overflow <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            state <= state_nx;
            if (clr) begin
                kp_cnt     <= '0;
                drop_cnt   <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (accept) kp_cnt <= kp_cnt + 16'd1;
                if (drop) begin
                    drop_cnt   <= sat_inc16(drop_cnt);
                    o_overflow <= 1'b1;
                end
            end
            // A start seen while the terminator waits for space opens the next frame directly.
            if (state == S_TERM && state_nx == S_TERM) begin
                if (i_start) start_pend <= 1'b1;
            end else begin
                start_pend <= 1'b0;
            end
        end
    end

    assign pop = ~fifo_empty & kp.kp_ready;

    kp_collector_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign kp.kp_valid = ~fifo_empty;
    assign kp.kp_data  = rdata[KP_W-1:0];
    assign kp.kp_eof   = rdata[KP_W];

endmodule

// File: tb/tb_kp_collector.sv
// Bench for kp_collector: directed frame scenarios plus a randomized phase, all outputs compared
// every cycle against a queue-based model of the record stream.
module tb_kp_collector;

    localparam int         DEPTH     = 64;
    localparam logic [7:0] MIN_SCORE = 8'd30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_in, en_in, fl_in;
    logic [7:0]  sc_in;
    logic [9:0]  x_in, y_in;
    logic [11:0] cos_in, sin_in;
    logic        frame_done, overflow;

    kp_collector_if kp_if();

    kp_collector #(.DEPTH(DEPTH), .MIN_SCORE(MIN_SCORE)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (st_in),
        .i_end          (en_in),
        .i_flag         (fl_in),
        .i_score        (sc_in),
        .i_coordinate_X (x_in),
        .i_coordinate_Y (y_in),
        .i_cos          (cos_in),
        .i_sin          (sin_in),
        .kp             (kp_if),
        .o_frame_done   (frame_done),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame phase (0 idle, 1 collecting, 2 terminating) and the expected FIFO.
    logic [52:0] mq[$];
    int          m_ph;
    int          m_kp, m_drop;
    bit          m_ovf, m_pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ph = 0; m_kp = 0; m_drop = 0; m_ovf = 0; m_pend = 0;
    endtask

    task automatic check_outputs();
        chk("kp_valid", 64'(kp_if.kp_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("kp_data", 64'(kp_if.kp_data), 64'(mq[0][51:0]));
            chk("kp_eof", 64'(kp_if.kp_eof), 64'(mq[0][52]));
        end else begin
            chk("kp_data_idle", 64'(kp_if.kp_data), 64'd0);
            chk("kp_eof_idle", 64'(kp_if.kp_eof), 64'd0);
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("frame_done", 64'(frame_done), 64'(m_ph == 2 && mq.size() < DEPTH));
    endtask

    task automatic model_edge(input logic st, input logic en, input logic fl, input logic [7:0] sc,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [11:0] c, input logic [11:0] s, input logic rdy);
        logic [52:0] rec;
        bit do_push, do_pop, kp, drop;
        rec = '0; do_push = 0; drop = 0;
        do_pop = (mq.size() > 0) && rdy;
        kp = fl;
`ifdef KP_SCORE_FILTER_EN
        if (sc < MIN_SCORE) kp = 0;
`endif
        case (m_ph)
            0: if (st) begin m_ph = 1; m_kp = 0; m_drop = 0; m_ovf = 0; end
            1: begin
                if (kp) begin
                    if (mq.size() < DEPTH - 1) begin
                        rec = {1'b0, x, y, sc, c, s};
                        do_push = 1;
                        m_kp = (m_kp + 1) % 65536;
                    end else drop = 1;
                end
                if (en) m_ph = 2;
            end
            default: begin
                drop = kp;
                if (mq.size() < DEPTH) begin
                    rec = {1'b1, 20'd0, 16'(m_drop), 16'(m_kp)};
                    do_push = 1;
                    if (m_pend || st) begin
                        m_ph = 1; m_kp = 0; m_drop = 0; m_ovf = 0; drop = 0;
                    end else m_ph = 0;
                    m_pend = 0;
                end else if (st) m_pend = 1;
            end
        endcase
        if (drop) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1;
        end
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(rec);
    endtask

    task automatic step(input logic st, input logic en, input logic fl, input logic [7:0] sc,
                        input logic [9:0] x, input logic [9:0] y,
                        input logic [11:0] c, input logic [11:0] s, input logic rdy);
        @(negedge clk);
        st_in = st; en_in = en; fl_in = fl; sc_in = sc;
        x_in = x; y_in = y; cos_in = c; sin_in = s;
        kp_if.kp_ready = rdy;
        #1 check_outputs();
        model_edge(st, en, fl, sc, x, y, c, s, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, rdy);
    endtask

    task automatic kpt(input logic st, input logic en, input logic rdy);
        step(st, en, 1'b1, 8'($urandom_range(30, 255)), 10'($urandom), 10'($urandom),
             12'($urandom), 12'($urandom), rdy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(kp_if.kp_valid), 64'd0);
        chk({tag, "_data"}, 64'(kp_if.kp_data), 64'd0);
        chk({tag, "_eof"}, 64'(kp_if.kp_eof), 64'd0);
        chk({tag, "_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int nrec, rdy_pct;
        rst_n = 1'b0;
        st_in = 0; en_in = 0; fl_in = 0; sc_in = 0; x_in = 0; y_in = 0; cos_in = 0; sin_in = 0;
        kp_if.kp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single keypoint frame, consumer always ready
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        step(0, 0, 1, 8'd40, 10'd100, 10'd50, 12'h7FF, 12'h000, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        chk("t1_rec", 64'(kp_if.kp_data), 64'h19032287FF000);
        idle(8, 1);
        step(0, 1, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        chk("t1_done", 64'(frame_done), 64'd1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        chk("t1_term", 64'({kp_if.kp_eof, kp_if.kp_data}), {11'd0, 1'b1, 52'h1});
        idle(3, 1);

        // Backpressure: 70 keypoints into a 64-deep FIFO with the consumer stalled
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        for (int i = 0; i < 70; i++) kpt(0, i == 69, 0);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t2_done", 64'(frame_done), 64'd1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t2_ovf", 64'(overflow), 64'd1);

        // Frame ends with the FIFO full; a start arrives while the terminator waits
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        for (int i = 0; i < 5; i++) kpt(0, i == 4, 0);
        for (int i = 0; i < 4; i++) begin
            step(i == 1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
            chk("t3_wait", 64'(frame_done), 64'd0);
        end
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t3_done", 64'(frame_done), 64'd1);
        step(0, 1, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        idle(62, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t2_term", 64'({kp_if.kp_eof, kp_if.kp_data}), {11'd0, 1'b1, 52'h7_003F});
        idle(1, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t3_term", 64'({kp_if.kp_eof, kp_if.kp_data}), {11'd0, 1'b1, 52'h5_0000});
        idle(10, 1);

        // Keypoint on the end cycle, restart during the terminator cycle
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        for (int i = 0; i < 4; i++) kpt(0, i == 3, 0);
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t4_done", 64'(frame_done), 64'd1);
        kpt(0, 0, 0);
        kpt(0, 1, 0);
        idle(2, 0);
        idle(4, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t4_term", 64'({kp_if.kp_eof, kp_if.kp_data}), {11'd0, 1'b1, 52'h4});
        idle(6, 1);

        // Scores straddling the filter threshold
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        step(0, 0, 1, 8'd29, 10'd1, 10'd2, 12'd3, 12'd4, 0);
        step(0, 0, 1, 8'd30, 10'd5, 10'd6, 12'd7, 12'd8, 0);
        step(0, 1, 1, 8'd31, 10'd9, 10'd10, 12'd11, 12'd12, 0);
        idle(2, 0);
`ifdef KP_SCORE_FILTER_EN
        nrec = 2;
`else
        nrec = 3;
`endif
        idle(nrec, 1);
        step(0, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        chk("t5_term", 64'({kp_if.kp_eof, kp_if.kp_data}), {11'd0, 1'b1, 52'(nrec)});
        idle(3, 1);

        // Reset mid-frame with entries queued
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        for (int i = 0; i < 5; i++) kpt(0, 0, 0);
        step(0, 0, 1, 8'd10, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        @(negedge clk);
        st_in = 0; en_in = 0; fl_in = 0;
        #2 rst_n = 1'b0;
        #1 check_zero("t6_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 8'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0);
        kpt(0, 0, 0);
        kpt(0, 1, 0);
        idle(4, 1);

        // Randomized traffic
        rdy_pct = 90;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rdy_pct = (i % 1500 == 0) ? 90 : ((i % 1000 == 0) ? 10 : 50);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4,
                 ($urandom_range(0, 1) == 1) ? 8'($urandom_range(25, 35)) : 8'($urandom),
                 10'($urandom), 10'($urandom), 12'($urandom), 12'($urandom),
                 $urandom_range(0, 99) < rdy_pct);
        end
        idle(DEPTH + 5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
